// File: rtl/ball_pkg.sv
// Shared definitions for the ball motion engine: FSM states, fixed-point widths, ball radius.
package ball_pkg;

    localparam int FIX_FRAC_W  = 5;   // position / velocity fraction bits (1/32 px)
    localparam int TRIG_FRAC_W = 8;   // cos/sin magnitude fraction bits (256 = 1.0)
    localparam int BALL_R      = 3;   // ball radius in pixels

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_MOVING = 3'd2,
        ST_UPDATE = 3'd3,
        ST_SUNK   = 3'd4
    } ball_state_e;

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

endpackage

// File: rtl/ball_axis_step.sv
// One axis of a frame update: integrate position, bounce off the walls, apply friction.
module ball_axis_step
    import ball_pkg::*;
#(
    parameter int LIMIT = 1280,
    parameter int DECEL = 1
) (
    input  logic [15:0]        i_pos,
    input  logic signed [15:0] i_vel,
    output logic [15:0]        o_pos,
    output logic signed [15:0] o_vel
);

    localparam logic signed [11:0] PX_LO   = 12'(BALL_R);
    localparam logic signed [11:0] PX_HI   = 12'(LIMIT - 5);
    localparam logic [15:0]        POS_LO  = 16'(BALL_R << FIX_FRAC_W);
    localparam logic [15:0]        POS_HI  = 16'((LIMIT - 5) << FIX_FRAC_W);
    localparam logic [16:0]        DECEL_U = 17'(DECEL);

    logic signed [16:0] w_sum;
    logic signed [11:0] w_px;
    logic signed [16:0] w_vel_b;
    logic [16:0]        w_mag;
    logic [16:0]        w_mag_f;

    assign w_sum = $signed({1'b0, i_pos}) + $signed({i_vel[15], i_vel});
    assign w_px  = w_sum[16:FIX_FRAC_W];

    always_comb begin
        o_pos   = w_sum[15:0];
        w_vel_b = {i_vel[15], i_vel};
        if (w_px < PX_LO) begin
            o_pos   = POS_LO;
            w_vel_b = -w_vel_b;
        end else if (w_px > PX_HI) begin
            o_pos   = POS_HI;
            w_vel_b = -w_vel_b;
        end
        // Friction acts on the magnitude so the direction never flips on its own.
        w_mag   = w_vel_b[16] ? unsigned'(-w_vel_b) : unsigned'(w_vel_b);
        w_mag_f = (w_mag > DECEL_U) ? (w_mag - DECEL_U) : 17'd0;
        o_vel   = 16'(w_vel_b[16] ? (17'd0 - w_mag_f) : w_mag_f);
    end

endmodule

// File: rtl/ball_motion.sv
// Golf-ball motion engine: shot loading, per-frame integration with wall bounce and friction.
// Define BALL_HOLE_EN to enable hole capture (SUNK state); the default build never sinks.
module ball_motion
    import ball_pkg::*;
#(
    parameter int SCREEN_W       = 1280,
    parameter int SCREEN_H       = 720,
    parameter int START_X        = 160,
    parameter int START_Y        = 360,
    parameter int DECEL          = 1,
    parameter int HOLE_X         = 1100,
    parameter int HOLE_Y         = 360,
    parameter int HOLE_MAX_SPEED = 64
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic        frame_tick,
    input  logic        shoot_valid,
    output logic        shoot_ready,
    input  logic [7:0]  power,
    input  logic [15:0] cos_abs,
    input  logic [15:0] sin_abs,
    input  logic        cos_sign,
    input  logic        sin_sign,
    input  logic        reset_ball,
    output logic [15:0] ballx,
    output logic [15:0] bally,
    output logic        moving,
    output logic        in_hole,
    output logic [7:0]  stroke_count
);

    localparam logic [15:0] TEE_X = 16'(START_X << FIX_FRAC_W);
    localparam logic [15:0] TEE_Y = 16'(START_Y << FIX_FRAC_W);

    ball_state_e        r_state;
    logic               r_phase;
    logic               r_armed;
    logic [15:0]        r_pos      [2];
    logic signed [15:0] r_vel      [2];
    logic [15:0]        r_step_pos [2];
    logic signed [15:0] r_step_vel [2];
    logic [7:0]         r_strokes;
    logic               r_in_hole;
    logic [7:0]         r_power;
    logic [15:0]        r_cos_abs;
    logic [15:0]        r_sin_abs;
    logic               r_cos_sign;
    logic               r_sin_sign;

    logic [15:0]        w_step_pos   [2];
    logic signed [15:0] w_step_vel   [2];
    logic [15:0]        w_commit_pos [2];
    logic signed [15:0] w_commit_vel [2];
    logic               w_hole_hit;
    logic [23:0]        w_prod_x;
    logic [23:0]        w_prod_y;
    logic [15:0]        w_mag_x;
    logic [15:0]        w_mag_y;
    logic signed [15:0] w_load_vx;
    logic signed [15:0] w_load_vy;
    logic               w_accept;

    for (genvar gi = 0; gi < 2; gi++) begin : g_axis
        ball_axis_step #(
            .LIMIT (gi == 0 ? SCREEN_W : SCREEN_H),
            .DECEL (DECEL)
        ) u_step (
            .i_pos (r_pos[gi]),
            .i_vel (r_vel[gi]),
            .o_pos (w_step_pos[gi]),
            .o_vel (w_step_vel[gi])
        );
    end

    // Magnitudes above the signed range saturate rather than wrap into the wrong direction.
    assign w_prod_x  = 24'(r_power) * 24'(r_cos_abs);
    assign w_prod_y  = 24'(r_power) * 24'(r_sin_abs);
    assign w_mag_x   = w_prod_x[23] ? 16'h7FFF : w_prod_x[23:TRIG_FRAC_W];
    assign w_mag_y   = w_prod_y[23] ? 16'h7FFF : w_prod_y[23:TRIG_FRAC_W];
    assign w_load_vx = r_cos_sign ? w_mag_x : -w_mag_x;
    assign w_load_vy = r_sin_sign ? -w_mag_y : w_mag_y;

    assign shoot_ready  = (r_state == ST_IDLE) && r_armed;
    assign w_accept     = shoot_valid && shoot_ready;
    assign moving       = (r_state == ST_LOAD) || (r_state == ST_MOVING) || (r_state == ST_UPDATE);
    assign ballx        = r_pos[0];
    assign bally        = r_pos[1];
    assign in_hole      = r_in_hole;
    assign stroke_count = r_strokes;

`ifdef BALL_HOLE_EN
    localparam logic [15:0] HOLE_POS_X = 16'(HOLE_X << FIX_FRAC_W);
    localparam logic [15:0] HOLE_POS_Y = 16'(HOLE_Y << FIX_FRAC_W);

    int w_dx;
    int w_dy;
    int w_speed;

    assign w_dx       = int'(r_step_pos[0][15:FIX_FRAC_W]) - HOLE_X;
    assign w_dy       = int'(r_step_pos[1][15:FIX_FRAC_W]) - HOLE_Y;
    assign w_speed    = iabs(int'(r_step_vel[0])) + iabs(int'(r_step_vel[1]));
    assign w_hole_hit = (iabs(w_dx) <= BALL_R) && (iabs(w_dy) <= BALL_R) && (w_speed <= HOLE_MAX_SPEED);

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_commit_pos[i] = r_step_pos[i];
            w_commit_vel[i] = r_step_vel[i];
        end
        if (w_hole_hit) begin
            w_commit_pos[0] = HOLE_POS_X;
            w_commit_pos[1] = HOLE_POS_Y;
            w_commit_vel[0] = '0;
            w_commit_vel[1] = '0;
        end
    end
`else
    assign w_hole_hit = 1'b0;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_commit_pos[i] = r_step_pos[i];
            w_commit_vel[i] = r_step_vel[i];
        end
    end
`endif

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state    <= ST_IDLE;
            r_phase    <= 1'b0;
            r_armed    <= 1'b0;
            r_pos[0]   <= TEE_X;
            r_pos[1]   <= TEE_Y;
            for (int i = 0; i < 2; i++) begin
                r_vel[i]      <= '0;
                r_step_pos[i] <= '0;
                r_step_vel[i] <= '0;
            end
            r_strokes  <= '0;
            r_in_hole  <= 1'b0;
            r_power    <= '0;
            r_cos_abs  <= '0;
            r_sin_abs  <= '0;
            r_cos_sign <= 1'b0;
            r_sin_sign <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            if (reset_ball) begin
                r_state   <= ST_IDLE;
                r_phase   <= 1'b0;
                r_pos[0]  <= TEE_X;
                r_pos[1]  <= TEE_Y;
                r_vel[0]  <= '0;
                r_vel[1]  <= '0;
                r_strokes <= '0;
                r_in_hole <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            r_power    <= power;
                            r_cos_abs  <= cos_abs;
                            r_sin_abs  <= sin_abs;
                            r_cos_sign <= cos_sign;
                            r_sin_sign <= sin_sign;
                            if (r_strokes != 8'hFF)
                                r_strokes <= r_strokes + 8'd1;
                            r_state <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        r_vel[0] <= w_load_vx;
                        r_vel[1] <= w_load_vy;
                        r_state  <= (w_load_vx == '0 && w_load_vy == '0) ? ST_IDLE : ST_MOVING;
                    end
                    ST_MOVING: begin
                        if (frame_tick) begin
                            r_state <= ST_UPDATE;
                            r_phase <= 1'b0;
                        end
                    end
                    ST_UPDATE: begin
                        // First cycle registers the step result; second commits both axes together.
                        if (!r_phase) begin
                            r_step_pos <= w_step_pos;
                            r_step_vel <= w_step_vel;
                            r_phase    <= 1'b1;
                        end else begin
                            r_phase <= 1'b0;
                            r_pos   <= w_commit_pos;
                            r_vel   <= w_commit_vel;
                            if (w_hole_hit) begin
                                r_in_hole <= 1'b1;
                                r_state   <= ST_SUNK;
                            end else if (w_commit_vel[0] == '0 && w_commit_vel[1] == '0) begin
                                r_state <= ST_IDLE;
                            end else begin
                                r_state <= ST_MOVING;
                            end
                        end
                    end
                    ST_SUNK: r_state <= ST_SUNK;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion: directed spec scenarios plus randomized shots vs. a frame-level model.
module tb_ball_motion;

    localparam int W   = 1280;
    localparam int H   = 720;
    localparam int SX  = 160;
    localparam int SY  = 360;
    localparam int DEC = 1;
    localparam int HX  = 1100;
    localparam int HY  = 360;
    localparam int HMS = 64;

    logic        pixel_clk_in = 1'b0;
    logic        rst_in;
    logic        frame_tick;
    logic        shoot_valid;
    logic        shoot_ready;
    logic [7:0]  power;
    logic [15:0] cos_abs;
    logic [15:0] sin_abs;
    logic        cos_sign;
    logic        sin_sign;
    logic        reset_ball;
    logic [15:0] ballx;
    logic [15:0] bally;
    logic        moving;
    logic        in_hole;
    logic [7:0]  stroke_count;

    int total = 0;
    int bad   = 0;

    // Reference model: ball state in 1/32 px units, one call per frame.
    int m_x, m_y, m_vx, m_vy, m_strokes;
    bit m_moving, m_sunk;

    ball_motion #(
        .SCREEN_W(W), .SCREEN_H(H), .START_X(SX), .START_Y(SY), .DECEL(DEC),
        .HOLE_X(HX), .HOLE_Y(HY), .HOLE_MAX_SPEED(HMS)
    ) dut (
        .pixel_clk_in (pixel_clk_in),
        .rst_in       (rst_in),
        .frame_tick   (frame_tick),
        .shoot_valid  (shoot_valid),
        .shoot_ready  (shoot_ready),
        .power        (power),
        .cos_abs      (cos_abs),
        .sin_abs      (sin_abs),
        .cos_sign     (cos_sign),
        .sin_sign     (sin_sign),
        .reset_ball   (reset_ball),
        .ballx        (ballx),
        .bally        (bally),
        .moving       (moving),
        .in_hole      (in_hole),
        .stroke_count (stroke_count)
    );

    always #5 pixel_clk_in = ~pixel_clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_tee();
        m_x = SX * 32; m_y = SY * 32; m_vx = 0; m_vy = 0;
        m_moving = 0; m_sunk = 0; m_strokes = 0;
    endtask

    task automatic model_axis(inout int p, inout int v, input int lim);
        int np;
        int mag;
        np = p + v;
        if ((np >>> 5) < 3) begin
            np = 3 * 32; v = -v;
        end else if ((np >>> 5) > lim - 5) begin
            np = (lim - 5) * 32; v = -v;
        end
        p   = np;
        mag = (v < 0) ? -v : v;
        mag = (mag > DEC) ? mag - DEC : 0;
        v   = (v < 0) ? -mag : mag;
    endtask

    task automatic model_frame();
        model_axis(m_x, m_vx, W);
        model_axis(m_y, m_vy, H);
        m_moving = (m_vx != 0) || (m_vy != 0);
`ifdef BALL_HOLE_EN
        begin
            int dx, dy, spd;
            dx  = (m_x >>> 5) - HX;
            dy  = (m_y >>> 5) - HY;
            spd = ((m_vx < 0) ? -m_vx : m_vx) + ((m_vy < 0) ? -m_vy : m_vy);
            if (dx >= -3 && dx <= 3 && dy >= -3 && dy <= 3 && spd <= HMS) begin
                m_x = HX * 32; m_y = HY * 32; m_vx = 0; m_vy = 0;
                m_moving = 0; m_sunk = 1;
            end
        end
`endif
    endtask

    task automatic state_check(input string tag);
        check({tag, ".ballx"},  32'(ballx), m_x);
        check({tag, ".bally"},  32'(bally), m_y);
        check({tag, ".moving"}, 32'(moving), 32'(m_moving));
        check({tag, ".stroke"}, 32'(stroke_count), m_strokes);
        check({tag, ".inhole"}, 32'(in_hole), 32'(m_sunk));
        check({tag, ".ready"},  32'(shoot_ready), 32'(!m_moving && !m_sunk));
    endtask

    task automatic do_shot(input int p, input int ca, input int cs, input int sa, input int ss);
        bit acc;
        @(negedge pixel_clk_in);
        power = 8'(p); cos_abs = 16'(ca); cos_sign = cs[0]; sin_abs = 16'(sa); sin_sign = ss[0];
        shoot_valid = 1'b1;
        acc = !m_moving && !m_sunk;
        @(negedge pixel_clk_in);
        shoot_valid = 1'b0;
        // Scramble inputs during LOAD: only the values at acceptance may matter.
        power = 8'($urandom); cos_abs = 16'($urandom); sin_abs = 16'($urandom);
        cos_sign = 1'($urandom); sin_sign = 1'($urandom);
        @(negedge pixel_clk_in);
        if (acc) begin
            if (m_strokes < 255) m_strokes++;
            m_vx = cs[0] ? (p * ca) / 256 : -((p * ca) / 256);
            m_vy = ss[0] ? -((p * sa) / 256) : (p * sa) / 256;
            m_moving = (m_vx != 0) || (m_vy != 0);
        end
        state_check("shot");
    endtask

    task automatic do_tick(input bit extra);
        @(negedge pixel_clk_in);
        frame_tick = 1'b1;
        @(negedge pixel_clk_in);
        frame_tick = extra;
        @(negedge pixel_clk_in);
        frame_tick = 1'b0;
        check("hold.ballx", 32'(ballx), m_x);
        check("hold.bally", 32'(bally), m_y);
        @(negedge pixel_clk_in);
        if (m_moving) model_frame();
        state_check("tick");
    endtask

    task automatic do_reset_ball();
        @(negedge pixel_clk_in);
        reset_ball = 1'b1; frame_tick = 1'b1; shoot_valid = 1'b1;
        @(negedge pixel_clk_in);
        reset_ball = 1'b0; frame_tick = 1'b0; shoot_valid = 1'b0;
        model_tee();
        state_check("rball");
    endtask

    task automatic run_to_rest(input int cap);
        for (int n = 0; n < cap && m_moving; n++) do_tick(1'($urandom));
        check("rest.moving", 32'(moving), 32'd0);
    endtask

    initial begin
        rst_in = 1'b0; frame_tick = 1'b0; shoot_valid = 1'b0; reset_ball = 1'b0;
        power = '0; cos_abs = '0; sin_abs = '0; cos_sign = 1'b0; sin_sign = 1'b0;
        model_tee();

        // Asynchronous reset: outputs settle before any clock edge.
        #2 rst_in = 1'b1;
        #1;
        check("rst.ballx", 32'(ballx), 32'h1400);
        check("rst.bally", 32'(bally), 32'h2D00);
        check("rst.ready", 32'(shoot_ready), 32'd0);
        check("rst.moving", 32'(moving), 32'd0);
        repeat (3) @(negedge pixel_clk_in);
        rst_in = 1'b0;
        repeat (2) @(negedge pixel_clk_in);
        check("idle.ballx", 32'(ballx), 32'h1400);
        check("idle.bally", 32'(bally), 32'h2D00);
        check("idle.ready", 32'(shoot_ready), 32'd1);
        check("idle.stroke", 32'(stroke_count), 32'd0);
        state_check("idle");

        // Straight shot to the right, then a rejected shot while moving.
        do_shot(128, 256, 1, 0, 0);
        do_tick(1'b0);
        check("shot1.x1", 32'(ballx), 32'h1480);
        do_tick(1'b1);
        check("shot1.x2", 32'(ballx), 32'h1480 + 127);
        do_shot(200, 256, 0, 256, 1);
        check("busy.stroke", 32'(stroke_count), 32'd1);
        run_to_rest(300);

        // Drive the ball to x=4px with vx=-64 to exercise the left wall.
        do_reset_ball();
        do_shot(78, 256, 1, 0, 0);
        run_to_rest(200);
        do_shot(142, 256, 0, 0, 0);
        for (int n = 0; n < 78; n++) do_tick(1'b0);
        check("wall.x4", 32'(ballx), 32'd128);
        do_tick(1'b0);
        check("wall.clamp", 32'(ballx), 32'd96);
        do_tick(1'b0);
        check("wall.rebound", 32'(ballx), 32'd96 + 63);
        run_to_rest(200);

        // Reset asserted in the middle of an UPDATE.
        do_reset_ball();
        do_shot(100, 256, 1, 256, 0);
        @(negedge pixel_clk_in);
        frame_tick = 1'b1;
        @(negedge pixel_clk_in);
        frame_tick = 1'b0;
        #2 rst_in = 1'b1;
        #1;
        check("midrst.ballx", 32'(ballx), SX * 32);
        check("midrst.bally", 32'(bally), SY * 32);
        check("midrst.moving", 32'(moving), 32'd0);
        check("midrst.stroke", 32'(stroke_count), 32'd0);
        check("midrst.ready", 32'(shoot_ready), 32'd0);
        @(negedge pixel_clk_in);
        rst_in = 1'b0;
        #1 check("midrst.ready0", 32'(shoot_ready), 32'd0);
        @(negedge pixel_clk_in);
        model_tee();
        state_check("midrst");

        // Randomized shots with occasional rejected shots and dropped ticks.
        for (int s = 0; s < 12; s++) begin
            if (m_sunk) do_reset_ball();
            do_shot($urandom_range(0, 200), $urandom_range(0, 256), $urandom_range(0, 1),
                    $urandom_range(0, 256), $urandom_range(0, 1));
            for (int n = 0; n < 400 && m_moving; n++) begin
                if ($urandom_range(0, 15) == 0)
                    do_shot($urandom_range(1, 255), 256, $urandom_range(0, 1), 256, $urandom_range(0, 1));
                do_tick(1'($urandom));
            end
            do_tick(1'b1);
        end

`ifdef BALL_HOLE_EN
        do_reset_ball();
        do_shot(250, 256, 1, 0, 0);
        run_to_rest(300);
        check("hole.inhole", 32'(in_hole), 32'd1);
        check("hole.ballx", 32'(ballx), HX * 32);
        do_tick(1'b1);
        do_shot(100, 256, 0, 0, 0);
        do_reset_ball();
        check("hole.cleared", 32'(in_hole), 32'd0);
`endif

        // Stroke counter saturation with zero-power shots.
        do_reset_ball();
        for (int s = 0; s < 300; s++) do_shot(0, 256, 1, 256, 1);
        check("sat.stroke", 32'(stroke_count), 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
